// File: rtl/viterbi_ber_monitor.sv
// BER monitor for the Viterbi path: learns the encoder-to-decoder latency from the
// transmit history, locks onto it, then counts decoded bits and bit errors.
module viterbi_ber_monitor #(
   parameter int MAX_LAT        = 64,
   parameter int LOCK_WINDOW    = 32,
   parameter int LOCK_ERR_MAX   = 2,
   parameter int UNLOCK_ERR_MAX = 8,
   parameter int CNT_W          = 32
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         tx_valid_i,
   input  logic                         tx_bit_i,
   input  logic                         rx_valid_i,
   input  logic                         rx_bit_i,
   input  logic                         clear_i,
   output logic                         locked_o,
   output logic [$clog2(MAX_LAT):0]     latency_o,
   output logic [CNT_W-1:0]             bit_cnt_o,
   output logic [CNT_W-1:0]             err_cnt_o,
   output logic                         err_pulse_o
);

   localparam int LAT_W  = $clog2(MAX_LAT) + 1;
   localparam int WIN_W  = (LOCK_WINDOW > 1) ? $clog2(LOCK_WINDOW) : 1;
   localparam int WERR_W = $clog2(LOCK_WINDOW) + 1;

   typedef enum logic [0:0] {
      ST_SEARCH = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t              state_r;
   logic [MAX_LAT-1:0]  hist_r;
   logic [WIN_W-1:0]    win_cnt_r;
   logic [WERR_W-1:0]   win_err_r;

   logic [LAT_W-1:0]    lat_idx_s;
   logic                mismatch_s;
   logic                win_end_s;
   logic [WERR_W-1:0]   win_err_nxt_s;
   logic [LAT_W-1:0]    next_lat_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      if (&value) begin
         return value;
      end else begin
         return value + CNT_W'(1);
      end
   endfunction

   assign locked_o = (state_r == ST_LOCKED);

   // Compare against pre-shift history and derive window/latency next values
   always_comb begin
      lat_idx_s     = latency_o - LAT_W'(1);
      mismatch_s    = rx_bit_i ^ hist_r[lat_idx_s[LAT_W-2:0]];
      win_end_s     = (win_cnt_r == WIN_W'(LOCK_WINDOW - 1));
      if (win_err_r == WERR_W'(LOCK_WINDOW)) begin
         win_err_nxt_s = win_err_r;
      end else begin
         win_err_nxt_s = win_err_r + WERR_W'(mismatch_s);
      end
      if (latency_o == LAT_W'(MAX_LAT)) begin
         next_lat_s = LAT_W'(1);
      end else begin
         next_lat_s = latency_o + LAT_W'(1);
      end
   end

   // History, search/lock FSM, windows and statistics counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= ST_SEARCH;
         hist_r      <= '0;
         win_cnt_r   <= '0;
         win_err_r   <= '0;
         latency_o   <= LAT_W'(1);
         bit_cnt_o   <= '0;
         err_cnt_o   <= '0;
         err_pulse_o <= 1'b0;
      end else begin
         err_pulse_o <= 1'b0;
         if (tx_valid_i) begin
            hist_r <= {hist_r[MAX_LAT-2:0], tx_bit_i};
         end
         if (clear_i) begin
            bit_cnt_o <= '0;
            err_cnt_o <= '0;
         end
         if (rx_valid_i) begin
            case (state_r)
               ST_SEARCH: begin
                  if (win_end_s) begin
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                     if (win_err_nxt_s <= WERR_W'(LOCK_ERR_MAX)) begin
                        state_r <= ST_LOCKED;
                     end else begin
                        latency_o <= next_lat_s;
                     end
                  end else begin
                     win_cnt_r <= win_cnt_r + WIN_W'(1);
                     win_err_r <= win_err_nxt_s;
                  end
               end
               ST_LOCKED: begin
                  err_pulse_o <= mismatch_s;
                  // A simultaneous clear discards this beat from the statistics
                  if (!clear_i) begin
                     bit_cnt_o <= sat_inc(bit_cnt_o);
                     if (mismatch_s) begin
                        err_cnt_o <= sat_inc(err_cnt_o);
                     end
                  end
                  if (win_err_nxt_s > WERR_W'(UNLOCK_ERR_MAX)) begin
                     state_r   <= ST_SEARCH;
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                  end else if (win_end_s) begin
                     win_cnt_r <= '0;
                     win_err_r <= '0;
                  end else begin
                     win_cnt_r <= win_cnt_r + WIN_W'(1);
                     win_err_r <= win_err_nxt_s;
                  end
               end
               default: begin
                  state_r   <= ST_SEARCH;
                  win_cnt_r <= '0;
                  win_err_r <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_viterbi_ber_monitor.sv
// Directed bench for viterbi_ber_monitor: PRBS7 tx, rx = tx delayed by 5 beats.
module tb_viterbi_ber_monitor;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        tx_valid_i = 1'b0;
   logic        tx_bit_i = 1'b0;
   logic        rx_valid_i = 1'b0;
   logic        rx_bit_i = 1'b0;
   logic        clear_i = 1'b0;

   logic        locked_o, err_pulse_o;
   logic [6:0]  latency_o;
   logic [31:0] bit_cnt_o, err_cnt_o;
   logic        s_locked, s_pulse;
   logic [6:0]  s_latency;
   logic [3:0]  s_bits, s_errs;

   int          errors = 0;
   int          checks = 0;
   int          pulses = 0;
   logic [6:0]  prbs = 7'h7F;
   logic [63:0] th = 64'd0;

   typedef struct {
      int          n;
      int          flip_at;
      logic        exp_locked;
      logic [6:0]  exp_lat;
      logic [31:0] exp_bits;
      logic [31:0] exp_errs;
   } seg_t;
   seg_t segs[10];

   always #5 clk = ~clk;

   viterbi_ber_monitor u_dut (
      .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
      .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
      .locked_o(locked_o), .latency_o(latency_o), .bit_cnt_o(bit_cnt_o),
      .err_cnt_o(err_cnt_o), .err_pulse_o(err_pulse_o)
   );

   viterbi_ber_monitor #(.CNT_W(4)) u_sat (
      .clk(clk), .rst(rst), .tx_valid_i(tx_valid_i), .tx_bit_i(tx_bit_i),
      .rx_valid_i(rx_valid_i), .rx_bit_i(rx_bit_i), .clear_i(clear_i),
      .locked_o(s_locked), .latency_o(s_latency), .bit_cnt_o(s_bits),
      .err_cnt_o(s_errs), .err_pulse_o(s_pulse)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One tx beat plus the matching rx beat (tx delayed by 5), optionally flipped
   task automatic beat(input logic flip, input logic clr);
      logic nb;
      nb = prbs[6] ^ prbs[5];
      prbs = {prbs[5:0], nb};
      tx_valid_i = 1'b1;
      tx_bit_i   = nb;
      rx_valid_i = 1'b1;
      rx_bit_i   = th[4] ^ flip;
      clear_i    = clr;
      @(posedge clk);
      th = {th[62:0], nb};
      #1;
      tx_valid_i = 1'b0;
      rx_valid_i = 1'b0;
      clear_i    = 1'b0;
      if (err_pulse_o) pulses++;
   endtask

   task automatic acquire(input string tag);
      for (int i = 0; i < 32; i++) beat(1'b0, 1'b0);
      chk({tag, "_lat_after_win1"}, 32'(latency_o), 32'd2);
      for (int i = 32; i < 159; i++) beat(1'b0, 1'b0);
      chk({tag, "_unlocked_159"}, 32'(locked_o), 32'd0);
      beat(1'b0, 1'b0);
      chk({tag, "_locked_160"}, 32'(locked_o), 32'd1);
      chk({tag, "_latency_160"}, 32'(latency_o), 32'd5);
      chk({tag, "_errs_160"}, err_cnt_o, 32'd0);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      th = 64'd0;
   endtask

   initial begin
      for (int k = 0; k < 10; k++)
         segs[k] = '{100, 50, 1'b1, 7'd5, 32'(100 * (k + 1)), 32'(k + 1)};

      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", 32'(locked_o), 32'd0);
      chk("rst_latency", 32'(latency_o), 32'd1);
      chk("rst_bits", bit_cnt_o, 32'd0);
      chk("rst_pulse", 32'(err_pulse_o), 32'd0);
      rst = 1'b0;

      acquire("align");
      chk("align_bits", bit_cnt_o, 32'd0);

      // Sparse errors: one flip every 100 locked beats
      pulses = 0;
      for (int s = 0; s < 10; s++) begin
         for (int i = 0; i < segs[s].n; i++) beat(i == segs[s].flip_at, 1'b0);
         chk("sparse_locked", 32'(locked_o), 32'(segs[s].exp_locked));
         chk("sparse_latency", 32'(latency_o), 32'(segs[s].exp_lat));
         chk("sparse_bits", bit_cnt_o, segs[s].exp_bits);
         chk("sparse_errs", err_cnt_o, segs[s].exp_errs);
      end
      chk("sparse_pulses", 32'(pulses), 32'd10);

      // Clear colliding with a flipped locked beat
      beat(1'b1, 1'b1);
      chk("clr_pulse", 32'(err_pulse_o), 32'd1);
      chk("clr_bits", bit_cnt_o, 32'd0);
      chk("clr_errs", err_cnt_o, 32'd0);
      chk("clr_locked", 32'(locked_o), 32'd1);
      beat(1'b0, 1'b0);
      chk("post_clr_bits", bit_cnt_o, 32'd1);
      chk("post_clr_pulse", 32'(err_pulse_o), 32'd0);

      // Asynchronous reset while locked, no clock edge needed
      #2;
      rst = 1'b1;
      #1;
      chk("async_locked", 32'(locked_o), 32'd0);
      chk("async_latency", 32'(latency_o), 32'd1);
      chk("async_bits", bit_cnt_o, 32'd0);
      repeat (3) @(posedge clk);
      #1;
      chk("held_locked", 32'(locked_o), 32'd0);
      rst = 1'b0;
      th = 64'd0;
      acquire("relock");

      clear_i = 1'b1;
      @(posedge clk); #1;
      clear_i = 1'b0;

      // Burst of 9 flips: lock lost on the 9th, latency kept as first candidate
      pulses = 0;
      for (int i = 0; i < 8; i++) beat(1'b1, 1'b0);
      chk("burst8_locked", 32'(locked_o), 32'd1);
      beat(1'b1, 1'b0);
      chk("burst9_locked", 32'(locked_o), 32'd0);
      chk("burst9_latency", 32'(latency_o), 32'd5);
      chk("burst9_errs", err_cnt_o, 32'd9);
      chk("burst9_bits", bit_cnt_o, 32'd9);
      chk("burst_pulses", 32'(pulses), 32'd9);
      for (int i = 0; i < 32; i++) beat(1'b1, 1'b0);
      chk("burst_latency6", 32'(latency_o), 32'd6);
      chk("burst_still_unlocked", 32'(locked_o), 32'd0);
      chk("burst_errs_hold", err_cnt_o, 32'd9);
      chk("burst_bits_hold", bit_cnt_o, 32'd9);

      // Saturation on the 4-bit counter instance
      do_reset();
      acquire("sat");
      chk("sat_locked", 32'(s_locked), 32'd1);
      for (int i = 0; i < 20; i++) beat(1'b0, 1'b0);
      chk("sat_bits15", 32'(s_bits), 32'd15);
      chk("sat_errs0", 32'(s_errs), 32'd0);
      chk("wide_bits20", bit_cnt_o, 32'd20);
      for (int i = 0; i < 80; i++) beat((i % 4) == 0, 1'b0);
      chk("sat_errs15", 32'(s_errs), 32'd15);
      chk("sat_bits_hold", 32'(s_bits), 32'd15);
      chk("sat_still_locked", 32'(s_locked), 32'd1);
      chk("wide_errs20", err_cnt_o, 32'd20);
      chk("wide_bits100", bit_cnt_o, 32'd100);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
